scan_capture: RTL and testbench

SCAN_CAPTURE -- requirements
Module: scan_capture

---
 rtl/scan_pkg.sv | 33 +++
 rtl/scan_capture_if.sv | 25 ++
 rtl/seg7_decode.sv | 22 ++
 rtl/scan_capture.sv | 148 ++++++++++++++
 tb/tb_scan_capture.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared types and tables for the scan_capture display-snooping block:
// FSM states, SEL-to-CAT one-hot map, 7-segment hex patterns, counter width.
package scan_pkg;

  typedef enum logic [2:0] {
    HUNT,
    CAP0,
    CAP1,
    CAP2,
    CAP3
  } state_t;

  localparam int ERR_COUNT_W = 8;

  // Entry [sel] is the CAT code expected while digit sel is driven.
  localparam logic [3:0][3:0] SEL_TO_CAT = {4'b0001, 4'b0010, 4'b0100, 4'b1000};

  // Entry [v] is the gfedcba pattern that displays hex digit v.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic state_t cap_state(input logic [1:0] sel);
    case (sel)
      2'd0:    return CAP0;
      2'd1:    return CAP1;
      2'd2:    return CAP2;
      default: return CAP3;
    endcase
  endfunction

endpackage

// File: rtl/scan_capture_if.sv
// Bundle of the scanner-side inputs and the captured-frame outputs of scan_capture.
// The master modport is the display scanner / consumer; slave is the capture block.
interface scan_capture_if;
  import scan_pkg::*;

  logic [1:0]             SEL;
  logic [3:0]             CAT;
  logic [6:0]             SEG;
  logic [15:0]            DIGITS;
  logic                   VALID;
  logic                   FRAME_DONE;
  logic                   ERR;
  logic [ERR_COUNT_W-1:0] ERR_COUNT;

  modport master (
    output SEL, CAT, SEG,
    input  DIGITS, VALID, FRAME_DONE, ERR, ERR_COUNT
  );

  modport slave (
    input  SEL, CAT, SEG,
    output DIGITS, VALID, FRAME_DONE, ERR, ERR_COUNT
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational 7-segment (gfedcba, active-high) to hex decoder with a legal flag.
module seg7_decode
  import scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       legal
);

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    value = '0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        value = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_capture.sv
// Snoops a multiplexed 4-digit 7-segment display bus and rebuilds the shown hex frame.
// Optional feature: define SCAN_DEBOUNCE_EN to require 2 identical samples per beat.
module scan_capture
  import scan_pkg::*;
(
  input  logic                   slow_clock,
  input  logic                   reset,
  input  logic [1:0]             SEL,
  input  logic [3:0]             CAT,
  input  logic [6:0]             SEG,
  output logic [15:0]            DIGITS,
  output logic                   VALID,
  output logic                   FRAME_DONE,
  output logic                   ERR,
  output logic [ERR_COUNT_W-1:0] ERR_COUNT
);

  state_t           state, state_n;
  logic [1:0]       smp_sel;
  logic [3:0]       smp_cat;
  logic [6:0]       smp_seg;
  logic [1:0]       last_sel;
  logic             have_last;
  logic [3:0][3:0]  shadow;
  logic [3:0]       seg_value;
  logic             seg_legal;
  logic             stable, beat, legal;
  logic [1:0]       expect_sel;
  logic             cap_en, publish, discard, err_n, done_n;

  seg7_decode u_decode (
    .seg   (smp_seg),
    .value (seg_value),
    .legal (seg_legal)
  );

`ifdef SCAN_DEBOUNCE_EN
  logic [1:0] prv_sel;
  logic [3:0] prv_cat;
  logic [6:0] prv_seg;

  always_ff @(posedge slow_clock) begin
    if (!reset) begin
      prv_sel <= '0;
      prv_cat <= '0;
      prv_seg <= '0;
    end else begin
      prv_sel <= smp_sel;
      prv_cat <= smp_cat;
      prv_seg <= smp_seg;
    end
  end

  assign stable = (smp_sel == prv_sel) && (smp_cat == prv_cat) && (smp_seg == prv_seg);
`else
  assign stable = 1'b1;
`endif

  // A beat is a new digit index on a non-blanked sample; dwell repeats are not beats.
  assign beat  = stable && (smp_cat != 4'b0000) && (!have_last || smp_sel != last_sel);
  assign legal = (smp_cat == SEL_TO_CAT[smp_sel]) && seg_legal;

  always_ff @(posedge slow_clock) begin
    if (!reset) state <= HUNT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    cap_en  = 1'b0;
    publish = 1'b0;
    discard = 1'b0;
    err_n   = 1'b0;
    done_n  = 1'b0;

    unique case (state)
      CAP0:    expect_sel = 2'd1;
      CAP1:    expect_sel = 2'd2;
      CAP2:    expect_sel = 2'd3;
      default: expect_sel = 2'd0;
    endcase

    if (beat) begin
      if (state == HUNT) begin
        // Only a digit-0 beat can open a frame; other indices pass silently.
        if (smp_sel == 2'd0) begin
          if (legal) begin
            cap_en  = 1'b1;
            state_n = CAP0;
          end else begin
            err_n = 1'b1;
          end
        end
      end else if (legal && smp_sel == expect_sel) begin
        cap_en  = 1'b1;
        publish = (state == CAP3);
        done_n  = (state == CAP3);
        state_n = cap_state(smp_sel);
      end else begin
        err_n   = 1'b1;
        discard = 1'b1;
        state_n = HUNT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values; publish and the new digit-0 capture rely on this.
  always_ff @(posedge slow_clock) begin
    if (!reset) begin
      smp_sel    <= '0;
      smp_cat    <= '0;
      smp_seg    <= '0;
      last_sel   <= '0;
      have_last  <= 1'b0;
      // NOTE: the shadow frame is a handful of flops, so it is cleared in reset
      // rather than treated as an unreset memory.
      shadow     <= '0;
      DIGITS     <= '0;
      VALID      <= 1'b0;
      FRAME_DONE <= 1'b0;
      ERR        <= 1'b0;
      ERR_COUNT  <= '0;
    end else begin
      smp_sel    <= SEL;
      smp_cat    <= CAT;
      smp_seg    <= SEG;
      FRAME_DONE <= done_n;
      ERR        <= err_n;

      if (beat) begin
        have_last <= 1'b1;
        last_sel  <= smp_sel;
      end

      if (discard) shadow <= '0;
      if (cap_en)  shadow[smp_sel] <= seg_value;

      if (publish) begin
        DIGITS <= shadow;
        VALID  <= 1'b1;
      end

      if (err_n && ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_scan_capture.sv
// Directed self-checking bench for scan_capture; honours SCAN_DEBOUNCE_EN for latency
// and the glitch-rejection scenario.
module tb_scan_capture;

`ifdef SCAN_DEBOUNCE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic slow_clock = 1'b0;
  logic reset      = 1'b0;
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   fd_pulses  = 0;
  int   err_pulses = 0;
  int   fd_snap, err_snap;

  scan_capture_if bus ();

  scan_capture dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .SEL        (bus.SEL),
    .CAT        (bus.CAT),
    .SEG        (bus.SEG),
    .DIGITS     (bus.DIGITS),
    .VALID      (bus.VALID),
    .FRAME_DONE (bus.FRAME_DONE),
    .ERR        (bus.ERR),
    .ERR_COUNT  (bus.ERR_COUNT)
  );

  always #5 slow_clock = ~slow_clock;

  always @(negedge slow_clock) begin
    if (bus.FRAME_DONE) fd_pulses++;
    if (bus.ERR)        err_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
      4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
      8: return 7'h7F;   9: return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E;  14: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [3:0] cat_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  // Advance to just after the next n falling edges (monitor has already sampled).
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge slow_clock);
      #1;
    end
  endtask

  task automatic send_raw(input logic [1:0] sel, input logic [3:0] cat,
                          input logic [6:0] seg, input int dwell);
    bus.SEL = sel;
    bus.CAT = cat;
    bus.SEG = seg;
    tick(dwell);
  endtask

  task automatic send(input logic [1:0] sel, input int v, input int dwell);
    send_raw(sel, cat_of(sel), seg_of(v), dwell);
  endtask

  initial begin
    bus.SEL = '0;
    bus.CAT = '0;
    bus.SEG = '0;
    reset   = 1'b0;
    tick(3);
    check("rst_digits", 32'(bus.DIGITS), 32'h0);
    check("rst_valid", 32'(bus.VALID), 32'h0);
    check("rst_done", 32'(bus.FRAME_DONE), 32'h0);
    check("rst_err", 32'(bus.ERR), 32'h0);
    check("rst_errcnt", 32'(bus.ERR_COUNT), 32'h0);
    reset = 1'b1;
    tick(2);

    // Clean frame 1,2,3,4 then SEL=00 publishes 0x4321.
    fd_snap = fd_pulses; err_snap = err_pulses;
    send(2'd0, 1, 3); send(2'd1, 2, 3); send(2'd2, 3, 3); send(2'd3, 4, 3);
    check("clean_no_early_done", 32'(fd_pulses - fd_snap), 32'd0);
    send(2'd0, 5, LAT - 1);
    check("clean_done_latency_early", 32'(bus.FRAME_DONE), 32'h0);
    tick(1);
    check("clean_done_pulse", 32'(bus.FRAME_DONE), 32'h1);
    check("clean_digits", 32'(bus.DIGITS), 32'h4321);
    check("clean_valid", 32'(bus.VALID), 32'h1);
    tick(1);
    check("clean_done_one_cycle", 32'(bus.FRAME_DONE), 32'h0);
    check("clean_no_err", 32'(err_pulses - err_snap), 32'd0);
    tick(1);

    // SEL=10 with the digit-1 CAT code while in CAP0.
    err_snap = err_pulses;
    send_raw(2'd2, 4'b0100, seg_of(6), 3);
    check("badcat_err_pulse", 32'(err_pulses - err_snap), 32'd1);
    check("badcat_errcnt", 32'(bus.ERR_COUNT), 32'd1);
    check("badcat_digits_kept", 32'(bus.DIGITS), 32'h4321);
    check("badcat_valid_kept", 32'(bus.VALID), 32'h1);
    send(2'd3, 9, 3);
    check("badcat_hunt_ignores", 32'(err_pulses - err_snap), 32'd1);

    // Out-of-order 00,01,11 then a later clean frame.
    fd_snap = fd_pulses; err_snap = err_pulses;
    send(2'd0, 7, 3); send(2'd1, 8, 3);
    send(2'd3, 9, LAT - 1);
    check("skip_err_early", 32'(bus.ERR), 32'h0);
    tick(1);
    check("skip_err_pulse", 32'(bus.ERR), 32'h1);
    tick(2);
    check("skip_errcnt", 32'(bus.ERR_COUNT), 32'd2);
    send(2'd0, 10, 3); send(2'd1, 11, 3); send(2'd2, 12, 3); send(2'd3, 13, 3);
    check("skip_no_done", 32'(fd_pulses - fd_snap), 32'd0);
    send(2'd0, 14, 4);
    check("skip_later_done", 32'(fd_pulses - fd_snap), 32'd1);
    check("skip_digits", 32'(bus.DIGITS), 32'hDCBA);
    check("skip_errs_total", 32'(err_pulses - err_snap), 32'd1);

    // Blank segment pattern on digit 2 discards the frame.
    fd_snap = fd_pulses; err_snap = err_pulses;
    send(2'd1, 1, 3);
    send_raw(2'd2, cat_of(2'd2), 7'h00, 3);
    check("badseg_err", 32'(err_pulses - err_snap), 32'd1);
    check("badseg_errcnt", 32'(bus.ERR_COUNT), 32'd3);
    send(2'd3, 4, 3);
    send(2'd0, 2, 4);
    check("badseg_discard", 32'(fd_pulses - fd_snap), 32'd0);
    check("badseg_digits_kept", 32'(bus.DIGITS), 32'hDCBA);

    // Frame 2,3,5,6 (with a one-cycle SEL glitch when debouncing).
    fd_snap = fd_pulses; err_snap = err_pulses;
    send(2'd1, 3, 3);
`ifdef SCAN_DEBOUNCE_EN
    send_raw(2'd3, cat_of(2'd3), seg_of(3), 1);
    send(2'd1, 3, 3);
`endif
    send(2'd2, 5, 3); send(2'd3, 6, 3);
    send(2'd0, 1, LAT - 1);
    check("glitch_done_early", 32'(bus.FRAME_DONE), 32'h0);
    tick(1);
    check("glitch_done", 32'(bus.FRAME_DONE), 32'h1);
    check("glitch_digits", 32'(bus.DIGITS), 32'h6532);
    check("glitch_no_err", 32'(err_pulses - err_snap), 32'd0);
    tick(1);

    // 300 forced violations: CAP0 followed by SEL=11.
    err_snap = err_pulses;
    for (int i = 0; i < 300; i++) begin
      send(2'd0, 1, LAT);
      send(2'd3, 1, LAT);
      if (i == 250) check("sat_254", 32'(bus.ERR_COUNT), 32'd254);
      if (i == 251) check("sat_255", 32'(bus.ERR_COUNT), 32'd255);
    end
    check("sat_pulses", 32'(err_pulses - err_snap), 32'd300);
    check("sat_hold", 32'(bus.ERR_COUNT), 32'd255);

    // Reset while in CAP2, then a full frame is needed.
    send(2'd0, 1, 3); send(2'd1, 2, 3); send(2'd2, 3, 1);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    check("mid_rst_digits", 32'(bus.DIGITS), 32'h0);
    check("mid_rst_valid", 32'(bus.VALID), 32'h0);
    check("mid_rst_errcnt", 32'(bus.ERR_COUNT), 32'h0);
    check("mid_rst_err", 32'(bus.ERR), 32'h0);
    check("mid_rst_done", 32'(bus.FRAME_DONE), 32'h0);
    fd_snap = fd_pulses;
    tick(2);
    send(2'd3, 4, 3); send(2'd0, 5, 4);
    check("mid_rst_no_done", 32'(fd_pulses - fd_snap), 32'd0);
    send(2'd1, 6, 3); send(2'd2, 7, 3); send(2'd3, 8, 3); send(2'd0, 9, 4);
    check("mid_rst_done_after_full", 32'(fd_pulses - fd_snap), 32'd1);
    check("mid_rst_digits_new", 32'(bus.DIGITS), 32'h8765);
    check("mid_rst_valid_new", 32'(bus.VALID), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
